// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - stallable pipelined adder/subtractor, one CW-bit chunk resolved per stage
// Optional feature macro: PIPE_ADDER_SUB_EN (builds subtract support on the sub input)
module pipe_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [0:WIDTH-1] a,
   input  logic [0:WIDTH-1] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:WIDTH-1] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int CW = WIDTH / STAGES;

   // Pipeline registers; stage k holds result chunks 0..k plus the untouched operand bits.
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] c_q;
   logic [STAGES-1:0] z_q;
   logic [STAGES-1:0] o_q;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];

   // Stage inputs (from the ports for stage 0, from the previous stage otherwise) and next values.
   logic [STAGES-1:0] src_v;
   logic [STAGES-1:0] src_c;
   logic [STAGES-1:0] src_z;
   logic [WIDTH-1:0]  src_a [STAGES];
   logic [WIDTH-1:0]  src_b [STAGES];
   logic [WIDTH-1:0]  src_s [STAGES];
   logic [WIDTH-1:0]  nxt_s [STAGES];
   logic [STAGES-1:0] nxt_c;
   logic [STAGES-1:0] nxt_z;
   logic [STAGES-1:0] nxt_o;
   logic [CW:0]       chunk;

   logic             en;
   logic [WIDTH-1:0] av;
   logic [WIDTH-1:0] bv;
   logic [WIDTH-1:0] beff;
   logic             cin_eff;

   // Ports number bit 0 as the LSB on an ascending range; remap to conventional descending vectors.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bits
      assign av[i]  = a[i];
      assign bv[i]  = b[i];
      assign sum[i] = s_q[STAGES-1][i];
   end

`ifdef PIPE_ADDER_SUB_EN
   // Subtract as a + ~b + 1; the inverted operand travels down the pipe so later chunks see it too.
   assign beff    = sub ? ~bv : bv;
   assign cin_eff = sub ? 1'b1 : cin;
`else
   logic unused_sub;
   assign unused_sub = sub;
   assign beff       = bv;
   assign cin_eff    = cin;
`endif

   // Whole pipe moves together unless a finished result is waiting on the consumer.
   assign en        = !out_valid || out_ready;
   assign in_ready  = en;
   assign out_valid = v_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = o_q[STAGES-1];
   assign zero      = z_q[STAGES-1];

   // Route stage sources, then resolve one chunk per stage with the carry handed in from upstream.
   always_comb begin
      src_v = '0;
      src_c = '0;
      src_z = '0;
      nxt_c = '0;
      nxt_z = '0;
      nxt_o = '0;
      chunk = '0;
      src_v[0] = in_valid;
      src_c[0] = cin_eff;
      src_z[0] = 1'b1;
      src_a[0] = av;
      src_b[0] = beff;
      src_s[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         src_v[k] = v_q[k-1];
         src_c[k] = c_q[k-1];
         src_z[k] = z_q[k-1];
         src_a[k] = a_q[k-1];
         src_b[k] = b_q[k-1];
         src_s[k] = s_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         chunk = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, src_b[k][k*CW +: CW]}
               + {{CW{1'b0}}, src_c[k]};
         nxt_s[k]              = src_s[k];
         nxt_s[k][k*CW +: CW]  = chunk[CW-1:0];
         nxt_c[k]              = chunk[CW];
         nxt_z[k]              = src_z[k] & (chunk[CW-1:0] == '0);
         // Carry into the chunk's top bit XOR carry out of it; only the last stage's value is used.
         nxt_o[k]              = src_a[k][k*CW+CW-1] ^ src_b[k][k*CW+CW-1]
                               ^ chunk[CW-1] ^ chunk[CW];
      end
   end

   // Shift every stage on advance; asynchronous reset discards everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         c_q <= '0;
         z_q <= '0;
         o_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else if (en) begin
         v_q <= src_v;
         c_q <= nxt_c;
         z_q <= nxt_z;
         o_q <= nxt_o;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= src_a[k];
            b_q[k] <= src_b[k];
            s_q[k] <= nxt_s[k];
         end
      end
   end

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder against an age-tracking scoreboard
module tb_pipe_adder;

   localparam int WIDTH  = 32;
   localparam int STAGES = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [0:31]   a;
   logic [0:31]   b;
   logic          cin;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [0:31]   sum;
   logic          cout;
   logic          ovf;
   logic          zero;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        o;
      logic        z;
      int          age;
   } op_t;

   op_t q[$];

   pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   function automatic logic [0:31] to_port(input logic [31:0] v);
      logic [0:31] r;
      for (int i = 0; i < 32; i++) r[i] = v[i];
      return r;
   endfunction

   function automatic logic [31:0] from_port(input logic [0:31] p);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = p[i];
      return r;
   endfunction

   // Arithmetic meaning of one operation, computed with wide integers.
   function automatic op_t ref_op(input logic [31:0] av, input logic [31:0] bv,
                                  input logic c, input logic s);
      op_t         r;
      logic [31:0] bb;
      logic        cc;
      logic [32:0] u;
      longint      wide;
      bb = bv;
      cc = c;
`ifdef PIPE_ADDER_SUB_EN
      if (s) begin
         bb = ~bv;
         cc = 1'b1;
      end
`else
      cc = c ^ (s & 1'b0);
`endif
      u    = {1'b0, av} + {1'b0, bb} + {32'd0, cc};
      wide = longint'($signed(av)) + longint'($signed(bb)) + longint'(cc);
      r.s   = u[31:0];
      r.c   = u[32];
      r.o   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      r.z   = (u[31:0] == 32'd0);
      r.age = 0;
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic model_out_valid();
      return (q.size() > 0) && (q[0].age == STAGES);
   endfunction

   task automatic check_out();
      logic ev;
      ev = model_out_valid();
      check("out_valid", out_valid, ev);
      if (ev) begin
         check("sum",  from_port(sum), q[0].s);
         check("cout", cout, q[0].c);
         check("ovf",  ovf,  q[0].o);
         check("zero", zero, q[0].z);
      end
   endtask

   // One clock: drive at negedge, check in_ready, advance the scoreboard at posedge, check outputs.
   task automatic step(input logic v, input logic [31:0] av, input logic [31:0] bv,
                       input logic c, input logic s, input logic ordy);
      logic ev;
      logic erdy;
      op_t  n;
      in_valid  = v;
      a         = to_port(av);
      b         = to_port(bv);
      cin       = c;
      sub       = s;
      out_ready = ordy;
      #1;
      ev   = model_out_valid();
      erdy = !ev || ordy;
      check("in_ready", in_ready, erdy);
      @(posedge clk);
      if (erdy) begin
         if (ev) void'(q.pop_front());
         foreach (q[i]) q[i].age++;
         if (v) begin
            n     = ref_op(av, bv, c, s);
            n.age = 1;
            q.push_back(n);
         end
      end
      @(negedge clk);
      check_out();
   endtask

   task automatic bubbles(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      #12;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sum",  from_port(sum), 32'd0);
      check("rst_cout", cout, 1'b0);
      check("rst_ovf",  ovf,  1'b0);
      check("rst_zero", zero, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Carry ripples through every chunk; latency checked cycle by cycle by the scoreboard.
      step(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
      bubbles(4);
      // Signed overflow, then carry-in.
      step(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h0000000F, 32'h00000001, 1'b1, 1'b0, 1'b1);
      bubbles(5);

      // Back-to-back full-rate stream.
      for (int i = 0; i < 8; i++) step(1'b1, 32'(i), 32'(16 * i), 1'b0, 1'b0, 1'b1);
      bubbles(5);

      // Fill the pipe, stall three cycles with a fifth op waiting, then release.
      for (int i = 0; i < 4; i++) step(1'b1, 32'(100 + i), 32'(i), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 32'd104, 32'd4, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'd104, 32'd4, 1'b0, 1'b0, 1'b1);
      bubbles(5);

      // Subtract (or plain add when the feature is not built).
      step(1'b1, 32'd5, 32'd7, 1'b0, 1'b1, 1'b1);
      bubbles(5);

      // Reset with three ops in flight and one stalled at the output.
      step(1'b1, 32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h00000003, 32'h00000004, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h00000005, 32'h00000006, 1'b0, 1'b0, 1'b0);
      check("pre_rst_valid", out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_sum", from_port(sum), 32'd0);
      check("mid_rst_in_ready", in_ready, 1'b1);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 32'h00000020, 32'h00000003, 1'b0, 1'b0, 1'b1);
      bubbles(5);

      // Randomized traffic with random back-pressure.
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 3) != 0, $urandom, $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0);
      end
      bubbles(8);
      check("drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
